uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of uart_top. It captures each byte presented on uart_top's rx_data when rx_done asserts, and stores the bytes in a circular FIFO. A consumer drains them through a registered read handshake. The block reports fill level, full/empty/almost-full and a sticky overrun flag, so that back-to-back frames are not lost while the consumer is busy.

---
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind uart_top: one write per rising edge of rx_done, circular storage, registered reads.
// Latency: rd_data/rd_valid one cycle after an accepted rd_en; a written byte is readable the cycle after its write.
// Backpressure: a write that finds the FIFO full and no read in the same cycle is dropped and sets sticky overrun.
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_done,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    input  logic                   clr_ovr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF  = LVL_W'(AF_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rx_done_q;

    logic wr_evt;
    logic rd_accept;
    logic wr_accept;
    logic wr_drop;

    assign empty       = (level == '0);
    assign full        = (level == LVL_MAX);
    assign almost_full = (level >= LVL_AF);

    // A full FIFO still takes the byte when a read frees a slot in the same cycle.
    assign wr_evt    = rx_done & ~rx_done_q;
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_evt & (~full | rd_accept);
    assign wr_drop   = wr_evt & full & ~rd_accept;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            rd_valid  <= rd_accept;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (rd_accept) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end

            case ({wr_accept, rd_accept})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase

            // A new drop outranks a clear arriving in the same cycle.
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based reference checked every cycle plus literal expectations.
module tb_uart_rx_fifo;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_done = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_ovr = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [4:0]        level;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .level(level), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of stored bytes, the last popped byte and a sticky flag.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rdd;
    logic              m_rdv;
    logic              m_ovr;
    logic              m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rdd  = '0;
            m_rdv  = 1'b0;
            m_ovr  = 1'b0;
            m_prev = 1'b0;
        end else begin
            bit evt, rd, drop;
            evt    = rx_done && !m_prev;
            m_prev = rx_done;
            rd     = rd_en && (q.size() > 0);
            drop   = 1'b0;
            m_rdv  = rd;
            if (rd) m_rdd = q.pop_front();
            if (evt) begin
                if (q.size() < DEPTH) q.push_back(rx_data);
                else drop = 1'b1;
            end
            if (drop) m_ovr = 1'b1;
            else if (clr_ovr) m_ovr = 1'b0;
        end
    end

    logic [DATA_W-1:0] got[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("level",       int'(level),       q.size());
            chk("empty",       int'(empty),       int'(q.size() == 0));
            chk("full",        int'(full),        int'(q.size() == DEPTH));
            chk("almost_full", int'(almost_full), int'(q.size() >= AF_LEVEL));
            chk("overrun",     int'(overrun),     int'(m_ovr));
            chk("rd_valid",    int'(rd_valid),    int'(m_rdv));
            chk("rd_data",     int'(rd_data),     int'(m_rdd));
            if (rd_valid) got.push_back(rd_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [DATA_W-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic rd_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        logic [DATA_W-1:0] basic [5];
        basic[0] = 8'h00; basic[1] = 8'h5E; basic[2] = 8'hA3; basic[3] = 8'hFF; basic[4] = 8'hC7;

        #1;
        chk("reset_level",   int'(level),    0);
        chk("reset_empty",   int'(empty),    1);
        chk("reset_full",    int'(full),     0);
        chk("reset_rdvalid", int'(rd_valid), 0);
        chk("reset_overrun", int'(overrun),  0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Basic order
        got.delete();
        for (int i = 0; i < 5; i++) wr_byte(basic[i]);
        chk("basic_level", int'(level), 5);
        rd_n(5);
        chk("basic_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("basic_data", int'(got[i]), int'(basic[i]));
        chk("basic_empty", int'(empty), 1);

        // Held strobe
        got.delete();
        rx_data = 8'h5E;
        rx_done = 1'b1;
        repeat (10) tick();
        rx_done = 1'b0;
        tick();
        chk("held_level", int'(level), 1);
        rd_n(1);
        chk("held_count", got.size(), 1);
        if (got.size() > 0) chk("held_data", int'(got[0]), 8'h5E);

        // Full and overrun
        got.delete();
        for (int i = 1; i <= 17; i++) wr_byte(DATA_W'(i));
        chk("ovr_full",    int'(full),    1);
        chk("ovr_level",   int'(level),   16);
        chk("ovr_overrun", int'(overrun), 1);
        rd_n(16);
        chk("ovr_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("ovr_data", int'(got[i]), i + 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tick();
        chk("ovr_cleared", int'(overrun), 0);

        // Wrap with concurrent write and read at full
        got.delete();
        for (int i = 0; i < 16; i++) wr_byte(DATA_W'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            rx_data = DATA_W'(8'h30 + i);
            rx_done = 1'b1;
            rd_en   = 1'b1;
            tick();
            rx_done = 1'b0;
            rd_en   = 1'b0;
            tick();
            chk("wrap_level", int'(level), 16);
        end
        chk("wrap_overrun", int'(overrun), 0);
        rd_n(16);
        chk("wrap_count", got.size(), 36);
        for (int i = 0; i < 36 && i < got.size(); i++) chk("wrap_data", int'(got[i]), 8'h20 + i);

        // Empty read and almost_full threshold
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rdvalid", int'(rd_valid), 0);
        chk("empty_rdhold",  int'(rd_data),  8'h43);
        tick();
        for (int i = 0; i < 11; i++) wr_byte(DATA_W'(8'h80 + i));
        chk("af_11", int'(almost_full), 0);
        wr_byte(8'h8B);
        chk("af_12", int'(almost_full), 1);

        // Async reset with level 7, overrun set and a read in flight
        for (int i = 0; i < 5; i++) wr_byte(DATA_W'(8'h90 + i));
        chk("pre_rst_overrun", int'(overrun), 1);
        rd_en = 1'b1;
        repeat (9) tick();
        rd_en = 1'b0;
        chk("pre_rst_level",   int'(level),    7);
        chk("pre_rst_rdvalid", int'(rd_valid), 1);
        rst_n   = 1'b0;
        rx_done = 1'b1;
        #1;
        chk("arst_level",   int'(level),       0);
        chk("arst_empty",   int'(empty),       1);
        chk("arst_af",      int'(almost_full), 0);
        chk("arst_rdvalid", int'(rd_valid),    0);
        chk("arst_overrun", int'(overrun),     0);
        chk("arst_rddata",  int'(rd_data),     0);
        rx_data = 8'hD4;
        #1;
        rst_n = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("post_rst_level", int'(level), 1);
        got.delete();
        rd_n(1);
        chk("post_rst_count", got.size(), 1);
        if (got.size() > 0) chk("post_rst_data", int'(got[0]), 8'hD4);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
